// File: rtl/pla_eval_arbiter_if.sv
// Request/response bundle between the requester harness and the PLA evaluation arbiter.
// No latency of its own; it only carries wires.
// Backpressure: req_ready grants one requester; rsp_ready stalls the response side.
interface pla_eval_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [12*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic [7:0]          rsp_data;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_ready;

  // Requester/consumer side.
  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/pla_eval_arbiter.sv
// Round-robin share of one 12-in/8-out PLA among N_REQ requesters, with the input vector held between grants.
// Latency: rsp_valid rises SETTLE_CYCLES edges after the accept edge.
// Backpressure: no grant while a transaction is open; the response is held until rsp_ready.
module pla_eval_arbiter #(
  parameter int N_REQ         = 4,
  parameter int ID_W          = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int ISO_ZERO      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pla_eval_arbiter_if.slave    bus,
  output logic [11:0]          pla_in,
  input  logic [7:0]           pla_out,
  output logic                 busy,
  output logic [15:0]          eval_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [ID_W-1:0] rr_last_q, rr_last_d;
  logic [11:0]     pla_in_q, pla_in_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     eval_count_q, eval_count_d;

  logic [N_REQ-1:0] grant;
  logic             grant_found;
  int               grant_pos;
  int               scan_idx;

  // Round-robin search starting just after the last winner; only offered while idle.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    grant_pos   = 0;
    scan_idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = (int'(rr_last_q) + k) % N_REQ;
      if (!grant_found && (state_q == IDLE) && bus.req_valid[scan_idx]) begin
        grant_found       = 1'b1;
        grant_pos         = scan_idx;
        grant[scan_idx]   = 1'b1;
      end
    end
  end

  // Next-state and datapath updates for the accept / settle / respond sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_last_d    = rr_last_q;
    pla_in_d     = pla_in_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    eval_count_d = eval_count_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          pla_in_d  = bus.req_data[grant_pos*12 +: 12];
          rsp_id_d  = ID_W'(grant_pos);
          rr_last_d = ID_W'(grant_pos);
          cnt_d     = 4'd0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          rsp_data_d  = pla_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (eval_count_q != 16'hFFFF) begin
            eval_count_d = eval_count_q + 16'd1;
          end
          // Optionally park the PLA inputs at zero so idle cycles cost no switching downstream.
          if (ISO_ZERO != 0) begin
            pla_in_d = '0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any open transaction without a response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      rr_last_q    <= ID_W'(N_REQ - 1);
      pla_in_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      eval_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_last_q    <= rr_last_d;
      pla_in_q     <= pla_in_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      eval_count_q <= eval_count_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign pla_in        = pla_in_q;
  assign busy          = (state_q != IDLE);
  assign eval_count    = eval_count_q;

endmodule

// File: tb/tb_pla_eval_arbiter.sv
// Self-checking bench: two arbiters (hold and zero isolation) on shared stimulus against a transaction-level model.
// Latency checked: response SETTLE edges after accept, next grant one cycle after handshake.
// Backpressure exercised through rsp_ready stalls and random consumer readiness.
module tb_pla_eval_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pla_eval_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus0 ();
  pla_eval_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus1 ();

  logic [11:0] pla_in0, pla_in1;
  logic [7:0]  pla_out0, pla_out1;
  logic        busy0, busy1;
  logic [15:0] cnt0, cnt1;

  // Stand-in PLA netlist.
  function automatic logic [7:0] plafn(input logic [11:0] x);
    return {x[11:8] ^ x[3:0], (x[7:4] & x[3:0]) | ~x[11:8]};
  endfunction

  assign pla_out0 = plafn(pla_in0);
  assign pla_out1 = plafn(pla_in1);

  assign bus1.req_valid = bus0.req_valid;
  assign bus1.req_data  = bus0.req_data;
  assign bus1.rsp_ready = bus0.rsp_ready;

  pla_eval_arbiter #(.N_REQ(N), .ID_W(IW), .SETTLE_CYCLES(ST), .ISO_ZERO(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .pla_in(pla_in0), .pla_out(pla_out0),
    .busy(busy0), .eval_count(cnt0)
  );

  pla_eval_arbiter #(.N_REQ(N), .ID_W(IW), .SETTLE_CYCLES(ST), .ISO_ZERO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .pla_in(pla_in1), .pla_out(pla_out1),
    .busy(busy1), .eval_count(cnt1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transaction-level reference: who owns the PLA, when it was granted, what it returns.
  bit          m_busy;
  int          m_last, m_acc, m_rid;
  logic [11:0] m_pin0, m_pin1;
  logic [7:0]  m_rdata;
  logic [15:0] m_cnt0, m_cnt1;

  logic [3:0] obs_g;
  int gq[$];
  int gcq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_last  = N - 1;
    m_acc   = 0;
    m_rid   = 0;
    m_pin0  = '0;
    m_pin1  = '0;
    m_rdata = '0;
    m_cnt0  = '0;
    m_cnt1  = '0;
  endtask

  function automatic int exp_winner(input logic [3:0] v);
    int w = -1;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int i = (m_last + k) % N;
        if (w < 0 && v[i]) w = i;
      end
    end
    return w;
  endfunction

  // One clock: drive, compare everything against the model, advance the model, tick.
  task automatic step(input logic [3:0] v, input logic [47:0] d, input logic rr, input logic rs);
    int w;
    logic [3:0] g;
    logic rv;
    bus0.req_valid = v;
    bus0.req_data  = d;
    bus0.rsp_ready = rr;
    rst_n          = rs;
    #1;
    w  = exp_winner(v);
    g  = (w >= 0) ? 4'(1 << w) : 4'd0;
    rv = m_busy && (cyc > m_acc + ST);
    obs_g = bus0.req_ready;
    for (int k = 0; k < N; k++) begin
      if (bus0.req_ready[k]) begin
        gq.push_back(k);
        gcq.push_back(cyc);
      end
    end
    chk("req_ready",  32'(bus0.req_ready), 32'(g));
    chk("rsp_valid",  32'(bus0.rsp_valid), 32'(rv));
    chk("rsp_data",   32'(bus0.rsp_data),  32'(m_rdata));
    chk("rsp_id",     32'(bus0.rsp_id),    32'(m_rid));
    chk("pla_in",     32'(pla_in0),        32'(m_pin0));
    chk("busy",       32'(busy0),          32'(m_busy));
    chk("eval_count", 32'(cnt0),           32'(m_cnt0));
    chk("iso_req_ready",  32'(bus1.req_ready), 32'(g));
    chk("iso_rsp_valid",  32'(bus1.rsp_valid), 32'(rv));
    chk("iso_rsp_data",   32'(bus1.rsp_data),  32'(m_rdata));
    chk("iso_pla_in",     32'(pla_in1),        32'(m_pin1));
    chk("iso_busy",       32'(busy1),          32'(m_busy));
    chk("iso_eval_count", 32'(cnt1),           32'(m_cnt1));
    if (!rs) begin
      model_reset();
    end else begin
      if (m_busy && cyc == m_acc + ST) m_rdata = plafn(m_pin0);
      if (rv && rr) begin
        m_busy = 1'b0;
        if (m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
        if (m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
        m_pin1 = '0;
      end
      if (w >= 0) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_pin0 = d[w*12 +: 12];
        m_pin1 = d[w*12 +: 12];
        m_rid  = w;
        m_last = w;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_busy; i++) step(4'd0, 48'd0, 1'b1, 1'b1);
    if (m_busy) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout observed=busy required=idle");
    end
  endtask

  task automatic run_txn(input logic [3:0] v, input logic [47:0] d);
    step(v, d, 1'b1, 1'b1);
    drain();
  endtask

  initial begin
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
    logic [7:0]  snap_data;
    logic [1:0]  snap_id;
    logic [11:0] snap_pin, prev_pin;
    int n, toggles, stray;
    logic [63:0] r;

    bus0.req_valid = '0;
    bus0.req_data  = '0;
    bus0.rsp_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();

    // Single request from requester 0.
    step(4'b0001, {36'd0, 12'hFFF}, 1'b0, 1'b1);
    chk("single_grant", 32'(obs_g), 32'h1);
    step(4'b0000, 48'd0, 1'b0, 1'b1);
    step(4'b0000, 48'd0, 1'b0, 1'b1);
    chk("single_rsp_valid", 32'(bus0.rsp_valid), 32'h1);
    chk("single_rsp_id",    32'(bus0.rsp_id),    32'h0);
    chk("single_rsp_data",  32'(bus0.rsp_data),  32'(plafn(12'hFFF)));
    step(4'b0000, 48'd0, 1'b1, 1'b1);
    chk("single_count", 32'(cnt0), 32'h1);

    // Round robin with every requester asking continuously.
    step(4'b0000, 48'd0, 1'b0, 1'b0);
    gq.delete();
    gcq.delete();
    for (int i = 0; i < 24; i++) step(4'b1111, 48'h123_456_789_ABC, 1'b1, 1'b1);
    if (gq.size() < 6) begin
      checks++;
      failures++;
      $display("FAIL rr_grant_count observed=%0d required>=6", gq.size());
    end else begin
      for (int i = 0; i < 6; i++) chk("rr_order", 32'(gq[i]), 32'(rr_exp[i]));
      for (int i = 1; i < 6; i++) chk("rr_spacing", 32'(gcq[i] - gcq[i-1]), 32'd4);
    end
    drain();

    // Backpressure: response held for 10 cycles.
    step(4'b0010, {24'd0, 12'hA5C, 12'd0}, 1'b0, 1'b1);
    for (int i = 0; i < 10 && !bus0.rsp_valid; i++) step(4'b0000, 48'd0, 1'b0, 1'b1);
    snap_data = bus0.rsp_data;
    snap_id   = bus0.rsp_id;
    snap_pin  = pla_in0;
    chk("bp_valid", 32'(bus0.rsp_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 48'hFFF_FFF_FFF_FFF, 1'b0, 1'b1);
      chk("bp_hold_valid", 32'(bus0.rsp_valid), 32'h1);
      chk("bp_hold_data",  32'(bus0.rsp_data),  32'(snap_data));
      chk("bp_hold_id",    32'(bus0.rsp_id),    32'(snap_id));
      chk("bp_hold_pin",   32'(pla_in0),        32'(snap_pin));
      chk("bp_no_grant",   32'(bus0.req_ready), 32'h0);
    end
    step(4'b0000, 48'd0, 1'b1, 1'b1);
    chk("bp_idle_after", 32'(busy0), 32'h0);
    chk("hold_pin_after", 32'(pla_in0), 32'hA5C);
    chk("iso_zero_after", 32'(pla_in1), 32'h0);

    // Idle isolation: no toggles on the held vector.
    toggles = 0;
    prev_pin = pla_in0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0000, 48'd0, 1'b0, 1'b1);
      if (pla_in0 !== prev_pin) toggles++;
      prev_pin = pla_in0;
    end
    chk("idle_toggles", 32'(toggles), 32'd0);

    // Reset during SETTLE.
    step(4'b0100, {12'd0, 12'h3C3, 24'd0}, 1'b0, 1'b1);
    step(4'b0000, 48'd0, 1'b0, 1'b1);
    step(4'b0000, 48'd0, 1'b1, 1'b0);
    chk("mr_busy",  32'(busy0),          32'h0);
    chk("mr_valid", 32'(bus0.rsp_valid), 32'h0);
    chk("mr_pin",   32'(pla_in0),        32'h0);
    chk("mr_count", 32'(cnt0),           32'h0);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step(4'b0000, 48'd0, 1'b1, 1'b1);
      if (bus0.rsp_valid !== 1'b0) stray++;
    end
    chk("mr_no_stray", 32'(stray), 32'd0);
    step(4'b1111, 48'h111_222_333_444, 1'b1, 1'b1);
    chk("mr_priority", 32'(obs_g), 32'h1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = {$urandom(), $urandom()};
      step(4'($urandom_range(0, 15)), r[47:0], ($urandom_range(0, 3) != 0), 1'b1);
    end
    drain();

    // Saturation of the completed-response counter.
    force dut0.eval_count_q = 16'hFFFE;
    m_cnt0 = 16'hFFFE;
    step(4'b0000, 48'd0, 1'b0, 1'b1);
    release dut0.eval_count_q;
    for (int t = 0; t < 3; t++) begin
      r = {$urandom(), $urandom()};
      run_txn(4'(1 << (t % N)), r[47:0]);
      chk("sat_count", 32'(cnt0), 32'hFFFF);
    end

    n = checks;
    $display("TB_RESULT checks=%0d failures=%0d", n, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
